e_mdu: RTL and testbench
========================

# e_mdu

Multi-cycle multiply/divide unit in the EX stage, alongside the combinational ALU. It executes MIPS `mult`/`multu`/`div`/`divu` into private HI/LO registers with a configurable latency, and services `mthi`/`mtlo` writes. It drives a `busy` flag that the hazard unit uses to stall later HI/LO users (`mfhi`/`mflo`/`mult`/…).

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu`; must be ≥ 1.
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu`; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch the operation in `MDOp` this cycle; valid only with a MULT/MULTU/DIV/DIVU op.
- `MDOp`  in  3  opcode: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE.
- `A`  in  WIDTH  rs operand: multiplicand or dividend; data source for MTHI/MTLO.
- `B`  in  WIDTH  rt operand: multiplier or divisor.
- `busy`  out  1  operation in flight.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.

## Operation
- Reset, asynchronous on `reset_n` low:
  - `HI`, `LO` and the result latches go to 0.
  - Cycle counter goes to 0 and `busy` goes to 0.
  - An in-flight operation is discarded with no commit.
- State machine:
  - IDLE → RUN on `start` with a mul/div op.
  - RUN → IDLE when the counter reaches 1 at an edge; HI/LO commit at that edge.
- Launch, at the edge sampling `start`=1 in IDLE:
  - Compute the result from `A`/`B` in the same cycle and capture it into result latches `hi_q`/`lo_q`.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES` according to the op.
  - Later changes on `A`/`B` do not affect the result.
- Arithmetic:
  - MULT: signed 2·WIDTH product; HI = upper half, LO = lower half.
  - MULTU: same as MULT, unsigned.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder carrying the sign of the dividend.
  - DIV with most-negative ÷ −1: LO = 0x8000_0000, HI = 0 (wraps, no trap).
  - DIVU: unsigned quotient and remainder.
  - Division by zero (B = 0) runs the full `DIV_CYCLES` but commits nothing; HI/LO keep their previous values.
- MTHI/MTLO, in IDLE only:
  - HI (or LO) ← `A` at the next edge; `busy` is not asserted.
  - `start` is ignored for these ops.
- While in RUN, `start` and MTHI/MTLO are ignored. The hazard unit stalls them, so this case is illegal but must be harmless.
- `HI`/`LO` outputs are register outputs; they change only at a commit edge or an MTHI/MTLO edge.

## Timing
- `start` sampled at edge E0. `busy` = 1 from just after E0 until just after E(N), where N is the op latency. HI/LO hold new values after E(N).
- `busy` is registered. The hazard unit must also treat `start`=1 in the current cycle as busy (stall = `start` | `busy`); that combination is external to this block.
- Back-to-back: a new `start` is accepted in the cycle immediately after `busy` falls. This gives a throughput of one op per N+1 cycles.
- MTHI/MTLO issued at the same edge that a commit happens cannot occur (the unit is in RUN), so no write-priority rule is needed.
- A `reset_n` assertion mid-RUN aborts the operation immediately. With `reset_n` released, the unit is in IDLE and reads 0/0.

## Structure
- Shared package `mdu_pkg`:
  - MDOp encodings as localparams: `MD_NONE` … `MD_MTLO`.
  - `MD_OP_W` = 3.
  - The main decoder imports this package to drive `MDOp`/`start`.
- One combinational sub-module, `e_mdu_calc`:
  - Inputs: `MDOp`, `A`, `B`.
  - Outputs: `{hi_res, lo_res, div_zero}`.
  - Handles the sign extension and the signed/unsigned quotient and remainder.
- The top `e_mdu` holds the counter, the FSM, the result latches and HI/LO.

## Test plan
- Reset, then MULT A=0xFFFF_FFFE (−2), B=3, MULT_CYCLES=5 → busy high for exactly 5 cycles. Then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA.
- MULTU A=0xFFFF_FFFF, B=0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV A=−7 (0xFFFF_FFF9), B=2 → after 10 busy cycles LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIVU A=7, B=2 → LO=3, HI=1.
- DIV A=0x8000_0000, B=0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- Divide by zero: first MTHI 0x1234 then MTLO 0x5678, neither raises `busy`. Then DIV B=0 → busy 10 cycles and HI/LO still 0x1234/0x5678.
- Abort and ignore:
  - MULT started, `reset_n` pulsed low at busy cycle 3 → busy=0 and HI=LO=0 immediately. The old result never appears.
  - `start` with a DIV during RUN is ignored; the original result commits on schedule.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared opcode encodings and FSM state type for the EX-stage multiply/divide unit.
// Imported by the decoder, the unit itself and its interface.
package mdu_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } mdu_state_t;

    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_muldiv(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || is_div(op);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Decoder-to-MDU bundle: launch/opcode/operands toward the unit,
// busy and HI/LO back toward the pipeline.
interface e_mdu_if #(
    parameter int WIDTH = 32
);
    import mdu_pkg::*;

    logic               start;
    logic [MD_OP_W-1:0] MDOp;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic [WIDTH-1:0]   HI;
    logic [WIDTH-1:0]   LO;

    modport master (
        output start, MDOp, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, MDOp, A, B,
        output busy, HI, LO
    );

endinterface

// File: rtl/e_mdu_calc.sv
// Combinational product / quotient / remainder for the MDU.
// Division works on magnitudes and re-applies signs afterwards.
module e_mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [MD_OP_W-1:0] MDOp,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [WIDTH-1:0]   hi_res,
    output logic [WIDTH-1:0]   lo_res,
    output logic               div_zero
);

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               sgn;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   q_u;
    logic [WIDTH-1:0]   r_u;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Low 2W bits of a product of sign-extended operands equal the signed product.
    assign ext_a  = {{WIDTH{A[WIDTH-1]}}, A};
    assign ext_b  = {{WIDTH{B[WIDTH-1]}}, B};
    assign prod_s = ext_a * ext_b;
    assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    assign sgn      = (MDOp == MD_DIV);
    assign neg_a    = sgn & A[WIDTH-1];
    assign neg_b    = sgn & B[WIDTH-1];
    assign mag_a    = neg_a ? (~A + 1'b1) : A;
    assign mag_b    = neg_b ? (~B + 1'b1) : B;
    assign div_zero = is_div(MDOp) && (B == '0);
    assign dvs      = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    assign q_u      = mag_a / dvs;
    assign r_u      = mag_a % dvs;
    // Most-negative / -1 yields magnitude 2^(W-1), which wraps back to itself.
    assign quot     = (neg_a ^ neg_b) ? (~q_u + 1'b1) : q_u;
    assign rem      = neg_a ? (~r_u + 1'b1) : r_u;

    always_comb begin
        hi_res = '0;
        lo_res = '0;
        unique case (MDOp)
            MD_MULT:         {hi_res, lo_res} = prod_s;
            MD_MULTU:        {hi_res, lo_res} = prod_u;
            MD_DIV, MD_DIVU: begin
                hi_res = rem;
                lo_res = quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// EX-stage multi-cycle multiply/divide unit with private HI/LO.
// Result is computed at launch and committed after a fixed latency.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic     clk,
    input logic     reset_n,
    e_mdu_if.slave  bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_t     state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic           dz_q;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic           busy_r;
    logic [WIDTH-1:0] hi_res;
    logic [WIDTH-1:0] lo_res;
    logic           div_zero;
    logic           launch;

    e_mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .MDOp     (bus.MDOp),
        .A        (bus.A),
        .B        (bus.B),
        .hi_res   (hi_res),
        .lo_res   (lo_res),
        .div_zero (div_zero)
    );

    assign launch   = bus.start && is_muldiv(bus.MDOp);
    assign bus.busy = busy_r;
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dz_q   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            busy_r <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (launch) begin
                        hi_q   <= hi_res;
                        lo_q   <= lo_res;
                        dz_q   <= div_zero;
                        cnt    <= is_div(bus.MDOp) ? CW'(DIV_CYCLES)
                                                   : CW'(MULT_CYCLES);
                        busy_r <= 1'b1;
                        state  <= S_RUN;
                    end else if (bus.MDOp == MD_MTHI) begin
                        hi_r <= bus.A;
                    end else if (bus.MDOp == MD_MTLO) begin
                        lo_r <= bus.A;
                    end
                end
                S_RUN: begin
                    // Inputs are ignored here; the hazard unit should be stalling them.
                    if (cnt == CW'(1)) begin
                        if (!dz_q) begin
                            hi_r <= hi_q;
                            lo_r <= lo_q;
                        end
                        cnt    <= '0;
                        busy_r <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Randomized scoreboard bench for e_mdu.
// Reference results come from plain 64-bit integer arithmetic.
module tb_e_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    e_mdu_if #(.WIDTH(32)) bus ();

    e_mdu #(
        .WIDTH       (32),
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
        exp_t        r;
        longint      p;
        longint      q;
        longint      rm;
        logic [63:0] pu;
        r.hi  = m_hi;
        r.lo  = m_lo;
        r.lat = (op == MD_DIV || op == MD_DIVU) ? DC : MC;
        if (op == MD_MULT) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (op == MD_MULTU) begin
            pu = {32'd0, a} * {32'd0, b};
            r.hi = pu[63:32];
            r.lo = pu[31:0];
        end else if (op == MD_DIV && b != 0) begin
            q  = longint'($signed(a)) / longint'($signed(b));
            rm = longint'($signed(a)) % longint'($signed(b));
            r.lo = q[31:0];
            r.hi = rm[31:0];
        end else if (op == MD_DIVU && b != 0) begin
            r.lo = a / b;
            r.hi = a % b;
        end
        return r;
    endfunction

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 40);
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic md;
        md = (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU);
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = md;
        if (md) begin
            e = ref_op(op, a, b);
            sb.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end else if (op == MD_MTHI) begin
            m_hi = a;
        end else if (op == MD_MTLO) begin
            m_lo = a;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.MDOp  = MD_NONE;
        bus.A     = $urandom;
        bus.B     = $urandom;
        if (md) begin
            wait_idle();
        end else begin
            chk("mt_busy", {31'd0, bus.busy}, 32'd0);
            chk("mt_hi", bus.HI, m_hi);
            chk("mt_lo", bus.LO, m_lo);
            @(negedge clk);
        end
    endtask

    // Monitor: each falling edge of busy is a commit to score.
    initial begin
        int   cyc;
        logic prev;
        exp_t e;
        cyc  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cyc  = 0;
                prev = 1'b0;
            end else begin
                if (bus.busy) begin
                    cyc++;
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: HI=%h LO=%h", bus.HI, bus.LO);
                    end else begin
                        e = sb.pop_front();
                        chk("commit_hi", bus.HI, e.hi);
                        chk("commit_lo", bus.LO, e.lo);
                        chk("latency", 32'(cyc), 32'(e.lat));
                    end
                    cyc = 0;
                end
                prev = bus.busy;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bus.start = 1'b0;
        bus.MDOp  = MD_NONE;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_op(MD_MULT,  32'hFFFF_FFFE, 32'd3);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
        chk("multu_lo", bus.LO, 32'h0000_0001);
        do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);
        do_op(MD_DIVU,  32'd7, 32'd2);
        chk("divu_lo", bus.LO, 32'd3);
        chk("divu_hi", bus.HI, 32'd1);
        do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_lo", bus.LO, 32'h8000_0000);
        chk("ovf_hi", bus.HI, 32'd0);

        do_op(MD_MTHI, 32'h1234, 32'd0);
        do_op(MD_MTLO, 32'h5678, 32'd0);
        do_op(MD_DIV,  32'd99, 32'd0);
        chk("dz_hi", bus.HI, 32'h1234);
        chk("dz_lo", bus.LO, 32'h5678);

        // Abort a MULT with reset at its third busy cycle.
        bus.MDOp  = MD_MULT;
        bus.A     = 32'd1000;
        bus.B     = 32'd77;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.MDOp  = MD_NONE;
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_hi", bus.HI, 32'd0);
        chk("abort_lo", bus.LO, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_late_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_late_hi", bus.HI, 32'd0);
        chk("abort_late_lo", bus.LO, 32'd0);

        // Start and MTHI issued during RUN must be ignored.
        e = ref_op(MD_DIV, 32'd100, 32'd7);
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        bus.MDOp  = MD_DIV;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.MDOp  = MD_NONE;
        @(negedge clk);
        bus.MDOp  = MD_DIV;
        bus.A     = $urandom;
        bus.B     = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.MDOp  = MD_MTHI;
        bus.A     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.MDOp  = MD_NONE;
        wait_idle();
        chk("ign_lo", bus.LO, 32'd14);
        chk("ign_hi", bus.HI, 32'd2);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: op = MD_MULT;
                1: op = MD_MULTU;
                2: op = MD_DIV;
                3: op = MD_DIVU;
                4: op = MD_MTHI;
                default: op = MD_MTLO;
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
            do_op(op, a, b);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("final_hi", bus.HI, m_hi);
        chk("final_lo", bus.LO, m_lo);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
